// File: rtl/reflet_power_manager_multi.sv
// Memory-mapped power manager: gates the CPU enable and a set of peripheral
// domain enables, with light/deep sleep and masked-interrupt wake-up followed
// by a programmable settle delay. Five byte registers on the peripheral bus.
module reflet_power_manager_multi #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10,
  parameter int                        nb_int         = 4,
  parameter int                        nb_domains     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  input  logic [nb_int-1:0]         ext_int,
  output logic                      cpu_enable,
  output logic [nb_domains-1:0]     domain_enable,
  output logic                      sleeping
);

  if (nb_int < 1 || nb_int > 8) begin : g_bad_nb_int
    $error("reflet_power_manager_multi: nb_int must be 1..8");
  end
  if (nb_domains < 1 || nb_domains > 8) begin : g_bad_nb_domains
    $error("reflet_power_manager_multi: nb_domains must be 1..8");
  end

  localparam logic [base_addr_size-1:0] addr_ctrl  = base_addr;
  localparam logic [base_addr_size-1:0] addr_mask  = base_addr + base_addr_size'(1);
  localparam logic [base_addr_size-1:0] addr_delay = base_addr + base_addr_size'(2);
  localparam logic [base_addr_size-1:0] addr_gate  = base_addr + base_addr_size'(3);
  localparam logic [base_addr_size-1:0] addr_wsrc  = base_addr + base_addr_size'(4);

  typedef enum logic [1:0] {RUN, ENTER, SLEEP, WAKE} state_t;

  state_t                state;
  logic                  deep;
  logic [7:0]            count;
  logic [nb_int-1:0]     mask;
  logic [7:0]            delay;
  logic [nb_domains-1:0] gate;
  logic [nb_int-1:0]     wsrc;

  logic hit_ctrl, hit_mask, hit_delay, hit_gate, hit_wsrc;
  logic wr_ctrl, wr_mask, wr_delay, wr_gate, wr_wsrc;
  logic [nb_int-1:0] wake_bits;
  logic [nb_int-1:0] wsrc_set;
  logic [nb_int-1:0] wsrc_clr;
  logic sleep_req;

  assign hit_ctrl  = enable && (addr == addr_ctrl);
  assign hit_mask  = enable && (addr == addr_mask);
  assign hit_delay = enable && (addr == addr_delay);
  assign hit_gate  = enable && (addr == addr_gate);
  assign hit_wsrc  = enable && (addr == addr_wsrc);

  assign wr_ctrl  = hit_ctrl  && write_en;
  assign wr_mask  = hit_mask  && write_en;
  assign wr_delay = hit_delay && write_en;
  assign wr_gate  = hit_gate  && write_en;
  assign wr_wsrc  = hit_wsrc  && write_en;

  assign wake_bits = ext_int & mask;
  assign wsrc_set  = (state == SLEEP) ? wake_bits : '0;
  assign wsrc_clr  = wr_wsrc ? data_in[nb_int-1:0] : '0;

  // An empty mask could never wake the CPU, so such a request is dropped.
  assign sleep_req = wr_ctrl && data_in[0] && (mask != '0) && (state == RUN);

  // Configuration registers and latched wake sources (set beats W1C clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask  <= '0;
      delay <= '0;
      gate  <= '0;
      wsrc  <= '0;
    end else begin
      if (wr_mask)  mask  <= data_in[nb_int-1:0];
      if (wr_delay) delay <= data_in;
      if (wr_gate)  gate  <= data_in[nb_domains-1:0];
      wsrc <= (wsrc & ~wsrc_clr) | wsrc_set;
    end
  end

  // Sleep sequencer with registered cpu_enable / sleeping outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      deep       <= 1'b0;
      count      <= '0;
      cpu_enable <= 1'b1;
      sleeping   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (sleep_req) begin
            state    <= ENTER;
            deep     <= data_in[1];
            sleeping <= 1'b1;
          end
        end
        ENTER: begin
          state      <= SLEEP;
          cpu_enable <= 1'b0;
        end
        SLEEP: begin
          if (wake_bits != '0) begin
            state <= WAKE;
            count <= delay;
          end
        end
        WAKE: begin
          if (count == 8'd0) begin
            state      <= RUN;
            cpu_enable <= 1'b1;
            sleeping   <= 1'b0;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Domain gating follows GATE live so bus updates during sleep apply at once.
  always_comb begin
    domain_enable = '1;
    if (state == SLEEP && deep) domain_enable = ~gate;
  end

  // Combinational read mux; drives zero when not addressed (OR-bus).
  always_comb begin
    data_out = '0;
    if (hit_ctrl) begin
      data_out[0] = sleeping;
      data_out[1] = deep;
    end else if (hit_mask) begin
      data_out[nb_int-1:0] = mask;
    end else if (hit_delay) begin
      data_out = delay;
    end else if (hit_gate) begin
      data_out[nb_domains-1:0] = gate;
    end else if (hit_wsrc) begin
      data_out[nb_int-1:0] = wsrc;
    end
  end

endmodule

// File: tb/tb_reflet_power_manager_multi.sv
// Scoreboard bench for reflet_power_manager_multi: the driver pushes the
// expected per-cycle outputs (and read data) from a timeline model of sleep
// episodes; a monitor on the falling edge pops and compares.
module tb_reflet_power_manager_multi;

  localparam int          NI   = 4;
  localparam int          ND   = 4;
  localparam logic [15:0] BASE = 16'hFF10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          write_en = 1'b0;
  logic [15:0]   addr = '0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic [NI-1:0] ext_int = '0;
  logic          cpu_enable;
  logic          sleeping;
  logic [ND-1:0] domain_enable;

  reflet_power_manager_multi #(
    .base_addr_size(16),
    .base_addr(BASE),
    .nb_int(NI),
    .nb_domains(ND)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .write_en(write_en),
    .ext_int(ext_int),
    .cpu_enable(cpu_enable),
    .domain_enable(domain_enable),
    .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cpu;
    logic          slp;
    logic [ND-1:0] dom;
    bit            rdc;
    logic [7:0]    rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference register state
  logic [7:0] m_mask, m_delay, m_gate, m_wsrc;
  logic       m_deep;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("cpu_enable", 8'(cpu_enable), 8'(e.cpu));
      chk("sleeping", 8'(sleeping), 8'(e.slp));
      chk("domain_enable", 8'(domain_enable), 8'(e.dom));
      if (e.rdc) chk("data_out", data_out, e.rd);
    end
  end

  task automatic model_reset();
    m_mask = '0; m_delay = '0; m_gate = '0; m_wsrc = '0; m_deep = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    case (off)
      16'd0:   return {6'b0, m_deep, 1'b0};
      16'd1:   return m_mask;
      16'd2:   return m_delay;
      16'd3:   return m_gate;
      16'd4:   return m_wsrc;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input int off, input logic [7:0] d);
    case (off)
      1: m_mask  = d & 8'h0F;
      2: m_delay = d;
      3: m_gate  = d & 8'h0F;
      4: m_wsrc  = m_wsrc & ~d;
      default: ;
    endcase
  endtask

  task automatic tick(input logic cpu, input logic slp, input logic [ND-1:0] dom,
                      input bit rdc, input logic [7:0] rd);
    exp_t e;
    e.cpu = cpu; e.slp = slp; e.dom = dom; e.rdc = rdc; e.rd = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic run_tick();
    tick(1'b1, 1'b0, '1, 1'b0, 8'h00);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    enable = 1'b1; write_en = 1'b1; addr = BASE + 16'(off); data_in = d;
    run_tick();
    bus_idle();
    model_write(off, d);
  endtask

  task automatic rd_addr(input logic [15:0] a, input bit en);
    enable = en; write_en = 1'b0; addr = a;
    tick(1'b1, 1'b0, '1, 1'b1, en ? model_read(a) : 8'h00);
    bus_idle();
  endtask

  task automatic rd(input int off);
    rd_addr(BASE + 16'(off), 1'b1);
  endtask

  // One sleep episode as a timeline: request, 1 ENTER cycle, k+1 SLEEP cycles
  // (wake line seen in SLEEP cycle k), m_delay+1 WAKE cycles, then RUN.
  task automatic episode(input bit dp, input int k_in, input bit pre, input bit w1c,
                         input int rst_at);
    logic [NI-1:0] wl, noise, wdat, gnew;
    int idx, k;
    bit gw;
    k = pre ? 0 : k_in;
    wdat = '0;
    idx = $urandom_range(0, NI-1);
    while (m_mask[idx] == 1'b0) idx = $urandom_range(0, NI-1);
    wl = NI'(1) << idx;
    noise = NI'($urandom) & ~m_mask[NI-1:0];
    ext_int = pre ? (wl | noise) : noise;
    // request
    enable = 1'b1; write_en = 1'b1; addr = BASE; data_in = {6'b0, dp, 1'b1};
    run_tick();
    bus_idle();
    m_deep = dp;
    // ENTER; a second request here must be ignored
    if ($urandom_range(0, 1) == 1) begin
      enable = 1'b1; write_en = 1'b1; addr = BASE; data_in = 8'h03;
    end
    tick(1'b1, 1'b1, '1, 1'b0, 8'h00);
    bus_idle();
    // SLEEP
    for (int j = 0; j <= k; j++) begin
      gw = 1'b0;
      gnew = '0;
      if (j == k) begin
        ext_int = ext_int | wl;
        if (w1c) begin
          wdat = NI'($urandom) | wl;
          enable = 1'b1; write_en = 1'b1; addr = BASE + 16'd4; data_in = 8'(wdat);
        end
      end else begin
        case ($urandom_range(0, 2))
          1: begin
            gnew = NI'($urandom);
            gw = 1'b1;
            enable = 1'b1; write_en = 1'b1; addr = BASE + 16'd3; data_in = 8'(gnew);
          end
          2: begin
            enable = 1'b1; write_en = 1'b1; addr = BASE; data_in = 8'h03;
          end
          default: ;
        endcase
      end
      tick(1'b0, 1'b1, m_deep ? ~m_gate[ND-1:0] : '1, 1'b0, 8'h00);
      bus_idle();
      if (gw) m_gate = 8'(gnew);
      if (j == k) m_wsrc = (m_wsrc & ~(w1c ? 8'(wdat) : 8'h00)) | 8'(wl);
    end
    ext_int = noise;
    // WAKE
    for (int w = 0; w <= int'(m_delay); w++) begin
      if (w == rst_at) reset = 1'b0;
      tick(1'b0, 1'b1, '1, 1'b0, 8'h00);
      if (w == rst_at) begin
        reset = 1'b1;
        model_reset();
        break;
      end
    end
    ext_int = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    for (int i = 0; i <= 5; i++) rd(i);

    // Light sleep, wake after a long sleep on ext_int[1]
    wr(1, 8'h02);
    episode(1'b0, 18, 1'b0, 1'b0, -1);
    rd(4); rd(0);

    // Deep sleep with gating and a settle delay
    wr(1, 8'h01); wr(2, 8'h05); wr(3, 8'h05);
    episode(1'b1, 4, 1'b0, 1'b0, -1);
    rd(4); rd(0);

    // Empty mask: request ignored
    wr(4, 8'hFF); wr(1, 8'h00); wr(0, 8'h03);
    run_tick(); run_tick();
    rd(0);

    // Line already high at request time, then W1C clear
    wr(1, 8'h04); wr(2, 8'h00);
    episode(1'b0, 0, 1'b1, 1'b0, -1);
    rd(4); wr(4, 8'h04); rd(4);

    // Randomised traffic and episodes
    repeat (30) begin
      repeat ($urandom_range(2, 6)) begin
        case ($urandom_range(0, 7))
          0: rd_addr(BASE + 16'($urandom_range(0, 7)), 1'b1);
          1: wr(1, 8'($urandom));
          2: wr(2, 8'($urandom) & 8'h0F);
          3: wr(3, 8'($urandom));
          4: wr(4, 8'($urandom));
          5: begin
            enable = 1'b0; write_en = 1'b1;
            addr = BASE + 16'($urandom_range(1, 3)); data_in = 8'($urandom);
            run_tick();
            bus_idle();
          end
          6: rd_addr(16'($urandom), 1'b1);
          default: wr(0, 8'($urandom) & 8'hFE);
        endcase
      end
      if (m_mask[3:0] != 4'h0) begin
        episode(1'($urandom_range(0, 1)), $urandom_range(0, 6),
                $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), -1);
      end else begin
        wr(0, 8'h01);
        run_tick();
      end
      rd(4); rd(0);
    end

    // Reset in the middle of a long WAKE
    wr(1, 8'h01); wr(2, 8'd200); wr(3, 8'h0F);
    episode(1'b1, 2, 1'b0, 1'b0, 10);
    for (int i = 0; i <= 4; i++) rd(i);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
